axi4l_mem_slave: RTL and testbench

- AXI4-Lite slave front end for the byte-lane scratch memory.
- Accepts AXI4-Lite write and read transactions and drives four 8-bit memory lanes as one 32-bit word memory; lane i is enabled by strobe bit i.
- Upstream neighbour of the 8-bit memory lanes: it produces their write address/data/enable/byte-enable and read address, and consumes their combinational read data.
- Write and read paths are independent FSMs, each with one outstanding transaction.

---
 rtl/axi4l_mem_slave_pkg.sv | 30 +++
 rtl/axi4l_mem_slave.sv | 181 ++++++++++++++++++
 tb/tb_axi4l_mem_slave.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_mem_slave_pkg.sv
// Shared definitions for the AXI4-Lite scratch-memory front end and its byte lanes.
package axi4l_mem_slave_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_MEM  = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_MEM  = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4l_mem_slave.sv
// AXI4-Lite slave that turns single-beat writes/reads into one-cycle accesses on the
// 4-lane byte memory; write and read paths are independent single-outstanding FSMs.
module axi4l_mem_slave
  import axi4l_mem_slave_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEMORY_SIZE      = 512
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   mem_waddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
  output logic                            mem_we,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] mem_be,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   mem_raddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rdata
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  w_state_e          w_state_q, w_state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]     be_q, be_d;

  r_state_e          r_state_q, r_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic              aw_fire, w_fire, ar_fire;

  assign aw_fire = s_axi_awvalid & awready_q;
  assign w_fire  = s_axi_wvalid & wready_q;
  assign ar_fire = s_axi_arvalid & arready_q;

  // A dropped ready doubles as the "channel already captured" flag while in W_IDLE.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    mem_we_d  = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          waddr_d   = s_axi_awaddr;
          awready_d = 1'b0;
        end
        if (w_fire) begin
          wdata_d  = s_axi_wdata;
          be_d     = s_axi_wstrb;
          wready_d = 1'b0;
        end
        if ((!awready_q || aw_fire) && (!wready_q || w_fire)) begin
          w_state_d = W_MEM;
          mem_we_d  = 1'b1;
        end
      end
      W_MEM: begin
        w_state_d = W_RESP;
        bvalid_d  = 1'b1;
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          raddr_d   = s_axi_araddr;
          arready_d = 1'b0;
          r_state_d = R_MEM;
        end
      end
      R_MEM: begin
        // Captured at the same edge a colliding lane write commits, so old data wins.
        rdata_d   = mem_rdata;
        rvalid_d  = 1'b1;
        r_state_d = R_RESP;
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      raddr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      mem_we_q  <= mem_we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign mem_waddr     = waddr_q;
  assign mem_wdata     = wdata_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = be_q;
  assign mem_raddr     = raddr_q;

endmodule

// File: tb/tb_axi4l_mem_slave.sv
// Randomized self-checking bench for axi4l_mem_slave with a word-level memory reference.
module tb_axi4l_mem_slave;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int we_cnt = 0;

  axi4l_mem_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_be(mem_be), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the four byte lanes: combinational read, write commits on the edge.
  logic [31:0] lane [0:511] = '{default: 32'h0};
  assign mem_rdata = lane[mem_raddr[10:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) lane[mem_waddr[10:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      we_cnt <= we_cnt + 1;
    end
  end

  // Reference: word-addressed memory, 512 words, addresses alias modulo the depth.
  logic [31:0] ref_mem [int];

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 512);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(widx(a))) return ref_mem[widx(a)];
    return 32'h0;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = ref_rd(a);
    for (int i = 0; i < 4; i++)
      if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[widx(a)] = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly);
    bit aw_done, w_done, aw_hs, w_hs, ok;
    int cyc, we0;
    we0 = we_cnt; aw_done = 0; w_done = 0; cyc = 0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    while (!(aw_done && w_done) && cyc < 100) begin
      s_axi_awvalid = !aw_done && cyc >= aw_dly;
      s_axi_wvalid  = !w_done && cyc >= w_dly;
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge clk);
      @(negedge clk);
      aw_done |= aw_hs; w_done |= w_hs; cyc++;
      if (!(aw_done && w_done) && we_cnt != we0) chk("we_early", we_cnt - we0, 0);
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    if (!(aw_done && w_done)) chk("wr_timeout", 0, 1);
    chk("mem_we", mem_we, 1);
    chk("mem_be", mem_be, strb);
    chk("mem_waddr", mem_waddr, addr);
    chk("mem_wdata", mem_wdata, data);
    @(negedge clk);
    chk("bvalid", s_axi_bvalid, 1);
    chk("bresp", s_axi_bresp, 0);
    ok = 1;
    repeat (b_dly) begin
      @(negedge clk);
      if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) ok = 0;
    end
    if (b_dly > 0) chk("b_stall", ok, 1);
    s_axi_bready = 1;
    @(negedge clk);
    s_axi_bready = 0;
    chk("b_done", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b011);
    chk("we_count", we_cnt - we0, 1);
    ref_wr(addr, data, strb);
  endtask

  task automatic rd_start(input logic [31:0] addr);
    bit hs;
    int cyc;
    hs = 0; cyc = 0;
    s_axi_araddr = addr;
    while (!hs && cyc < 100) begin
      s_axi_arvalid = 1;
      hs = s_axi_arready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    s_axi_arvalid = 0;
    if (!hs) chk("rd_timeout", 0, 1);
    chk("rvalid_mem_phase", s_axi_rvalid, 0);
    @(negedge clk);
    chk("rvalid", s_axi_rvalid, 1);
    chk("rresp", s_axi_rresp, 0);
  endtask

  task automatic rd_finish(input string tag, input logic [31:0] exp, input int r_dly);
    bit ok;
    chk(tag, s_axi_rdata, exp);
    ok = 1;
    repeat (r_dly) begin
      @(negedge clk);
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp) ok = 0;
    end
    if (r_dly > 0) chk("r_stall", ok, 1);
    s_axi_rready = 1;
    @(negedge clk);
    s_axi_rready = 0;
    chk("r_done", {s_axi_rvalid, s_axi_arready}, 2'b01);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input int r_dly);
    logic [31:0] exp;
    exp = ref_rd(addr);
    rd_start(addr);
    rd_finish(tag, exp, r_dly);
  endtask

  initial begin
    logic [31:0] old, a, d;
    rst_n = 0;
    s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    repeat (3) @(negedge clk);
    chk("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    chk("rst_valids", {s_axi_bvalid, s_axi_rvalid, mem_we}, 3'b000);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_mem_out", {mem_waddr | mem_wdata | mem_raddr, 28'h0, mem_be} == 0, 1);
    rst_n = 1;
    @(negedge clk);

    // Same-cycle AW/W, then read back
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read("rd_10", 32'h10, 0);
    chk("rd_10_const", s_axi_rdata, 32'hDEADBEEF);

    // W leads AW by 3 cycles, partial strobe over all-ones
    do_write(32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(32'h20, 32'h11223344, 4'h5, 3, 0, 0);
    do_read("rd_20", 32'h20, 0);
    chk("rd_20_const", s_axi_rdata, 32'hFF22FF44);

    // B stall for 5 cycles; zero strobe leaves data intact
    do_write(32'h20, 32'h0, 4'h0, 0, 2, 5);
    do_read("rd_20_zstrb", 32'h23, 0);

    // R stall with a write to the same word while rdata is held
    rd_start(32'h10);
    do_write(32'h10, 32'h12345678, 4'hF, 0, 0, 0);
    rd_finish("rd_stall_held", 32'hDEADBEEF, 4);
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);

    // Read and write memory phases in the same cycle on one word
    old = ref_rd(32'h10);
    s_axi_awaddr = 32'h10; s_axi_wdata = 32'h0; s_axi_wstrb = 4'hF; s_axi_araddr = 32'h10;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    @(negedge clk);
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    chk("coll_we", mem_we, 1);
    @(negedge clk);
    chk("coll_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b11);
    chk("coll_rdata", s_axi_rdata, old);
    ref_wr(32'h10, 32'h0, 4'hF);
    s_axi_bready = 1; s_axi_rready = 1;
    @(negedge clk);
    s_axi_bready = 0; s_axi_rready = 0;
    do_read("coll_after", 32'h10, 0);

    // Reset while both paths hold a response
    s_axi_awaddr = 32'h30; s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF; s_axi_araddr = 32'h10;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    @(negedge clk);
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    @(negedge clk);
    chk("pre_rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b11);
    ref_wr(32'h30, 32'hCAFEF00D, 4'hF);
    #2 rst_n = 0;
    #1 chk("async_rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    do_write(32'h34, 32'hA5A5A5A5, 4'hF, 1, 0, 1);
    do_read("post_rst_rd", 32'h34, 0);
    do_read("post_rst_rd30", 32'h30, 0);

    // Randomized traffic, including aliased and unaligned addresses
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = a + 32'h800 * $urandom_range(1, 3);
      d = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read("rand_rd", a, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
